// File: rtl/escalonador_datapath_if.sv
// Requester bus plus control-FSM handshake shared by the round-robin scheduler.
// slave = scheduler side, master = requesters / control FSM side.
interface escalonador_datapath_if #(
    parameter int NREQ = 4,
    parameter int W    = 16
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      resp_y;
    logic              resp_err;
    logic              inicio;
    logic [W-1:0]      x_out;
    logic              done;
    logic [W-1:0]      y_in;
    logic              busy;

    modport master (
        output req, req_x, done, y_in,
        input  gnt, ack, resp_y, resp_err, inicio, x_out, busy
    );

    modport slave (
        input  req, req_x, done, y_in,
        output gnt, ack, resp_y, resp_err, inicio, x_out, busy
    );
endinterface

// File: rtl/escalonador_datapath.sv
// Round-robin scheduler sharing one BOBC datapath among NREQ requesters,
// with a watchdog that aborts a job whose done never arrives.
module escalonador_datapath #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 32
) (
    input  logic                    ck,
    input  logic                    rst,
    escalonador_datapath_if.slave   bus
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW   = $clog2(TIMEOUT);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    y_q, y_d;
    logic            err_q, err_d;

    logic [IDXW-1:0] pick;
    logic [IDXW:0]   cand;
    logic            found;
    logic [NREQ-1:0] own;

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (IDXW+1)'(i);
            if (cand >= (IDXW+1)'(NREQ)) cand = cand - (IDXW+1)'(NREQ);
            if (!found && bus.req[cand[IDXW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDXW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    idx_d   = pick;
                    x_d     = bus.req_x[pick*W +: W];
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // done takes priority over the watchdog expiring in the same cycle
                if (bus.done) begin
                    y_d     = bus.y_in;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timer_q == TW'(TIMEOUT-1)) begin
                    y_d     = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                ptr_d   = (idx_q == IDXW'(NREQ-1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    assign own          = NREQ'(1) << idx_q;
    assign bus.gnt      = (state_q != IDLE) ? own : '0;
    assign bus.ack      = (state_q == RESP) ? own : '0;
    assign bus.resp_y   = (state_q == RESP) ? y_q : '0;
    assign bus.resp_err = (state_q == RESP) & err_q;
    assign bus.inicio   = (state_q == LAUNCH);
    assign bus.x_out    = x_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_escalonador_datapath.sv
// Directed plus randomized bench for escalonador_datapath against a job-level
// round-robin / watchdog reference model.
module tb_escalonador_datapath;
    localparam int NREQ    = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 32;

    logic ck = 1'b0;
    logic rst;
    always #5 ck = ~ck;

    escalonador_datapath_if #(.NREQ(NREQ), .W(W)) bus ();

    escalonador_datapath #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int model_ptr = 0;
    logic [W-1:0] opnd [NREQ];
    int acnt [NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) bus.req_x[i*W +: W] = opnd[i];
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"},    bus.gnt, 0);
        chk({tag, "_ack"},    bus.ack, 0);
        chk({tag, "_resp_y"}, bus.resp_y, 0);
        chk({tag, "_err"},    bus.resp_err, 0);
        chk({tag, "_inicio"}, bus.inicio, 0);
        chk({tag, "_x_out"},  bus.x_out, 0);
        chk({tag, "_busy"},   bus.busy, 0);
    endtask

    // Entered at an IDLE negedge with req already driven; returns at the next IDLE negedge.
    // dly = WAIT cycle (1-based) in which done is pulsed; 0 or >TIMEOUT means never.
    task automatic job(input int dly, input logic [W-1:0] y, input bit spur,
                       input bit drop, input bit hold, output int g_obs);
        int e;
        bit seen;
        bit tmo;
        logic [NREQ-1:0] oh;
        logic [W-1:0] ey;
        e     = rr_pick(bus.req, model_ptr);
        oh    = NREQ'(1) << e;
        tmo   = (dly == 0) || (dly > TIMEOUT);
        ey    = tmo ? '0 : y;
        seen  = 1'b0;
        g_obs = -1;
        for (int k = 0; k < 4; k++) begin
            @(negedge ck);
            if (bus.inicio) begin
                seen = 1'b1;
                chk("launch_latency", k, 0);
                break;
            end
        end
        chk("inicio_seen", {31'b0, seen}, 1);
        if (!seen) return;
        for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) g_obs = i;
        chk("launch_gnt", bus.gnt, oh);
        chk("launch_x", bus.x_out, opnd[e]);
        chk("launch_ack", bus.ack, 0);
        if (spur) begin
            bus.done = 1'b1;
            bus.y_in = W'($urandom);
        end
        if (drop) bus.req[e] = 1'b0;
        for (int w = 1; w <= TIMEOUT; w++) begin
            @(negedge ck);
            chk("wait_gnt", bus.gnt, oh);
            chk("wait_ack", bus.ack, 0);
            chk("wait_inicio", bus.inicio, 0);
            bus.done = (w == dly);
            bus.y_in = (w == dly) ? y : W'($urandom);
            if (w == dly) break;
        end
        @(negedge ck);
        bus.done = 1'($urandom_range(0, 1));
        bus.y_in = W'($urandom);
        chk("resp_ack", bus.ack, oh);
        chk("resp_y", bus.resp_y, ey);
        chk("resp_err", bus.resp_err, tmo);
        chk("resp_busy", bus.busy, 1);
        for (int i = 0; i < NREQ; i++) acnt[i] += int'(bus.ack[i]);
        model_ptr = (e + 1) % NREQ;
        if (!hold) bus.req[e] = 1'b0;
        @(negedge ck);
        bus.done = 1'b0;
        chk("idle_ack", bus.ack, 0);
        chk("idle_gnt", bus.gnt, 0);
        chk("idle_busy", bus.busy, 0);
    endtask

    initial begin
        int g;
        rst      = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        bus.y_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            opnd[i] = W'($urandom);
            acnt[i] = 0;
        end
        drive_ops();
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge ck);
        rst = 1'b1;
        @(negedge ck);

        // single job, done in 10th WAIT cycle
        opnd[2] = 16'h0012;
        drive_ops();
        bus.req = 4'b0100;
        job(10, 16'h0345, 1'b0, 1'b0, 1'b0, g);
        chk("single_gnt_idx", g, 2);

        // asynchronous reset in the middle of WAIT
        bus.req = 4'b0010;
        repeat (3) @(negedge ck);
        chk("pre_reset_busy", bus.busy, 1);
        #2 rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        bus.req = '0;
        @(negedge ck);
        rst = 1'b1;
        model_ptr = 0;
        @(negedge ck);

        // fairness with all requests held
        for (int i = 0; i < NREQ; i++) acnt[i] = 0;
        bus.req = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            job(5, W'($urandom), 1'b0, 1'b0, 1'b1, g);
            chk("rr_order", g, j % NREQ);
        end
        for (int i = 0; i < NREQ; i++) chk("rr_ack_count", acnt[i], 2);

        // watchdog timeout then a normal job
        bus.req = 4'b0001;
        job(0, 16'hBEEF, 1'b0, 1'b0, 1'b0, g);
        bus.req = 4'b0001;
        job(7, W'($urandom), 1'b0, 1'b0, 1'b0, g);

        // spurious done in IDLE and LAUNCH
        bus.done = 1'b1;
        repeat (3) begin
            bus.y_in = W'($urandom);
            @(negedge ck);
            chk("spur_idle_busy", bus.busy, 0);
            chk("spur_idle_ack", bus.ack, 0);
            chk("spur_idle_inicio", bus.inicio, 0);
        end
        bus.done = 1'b0;
        bus.req  = 4'b1000;
        job(3, W'($urandom), 1'b1, 1'b0, 1'b0, g);

        // done exactly at the last watchdog cycle; req dropped after launch
        bus.req = 4'b0100;
        job(TIMEOUT, 16'h7A5C, 1'b0, 1'b0, 1'b0, g);
        bus.req = 4'b0010;
        job(6, W'($urandom), 1'b0, 1'b1, 1'b0, g);

        // randomized jobs
        for (int j = 0; j < 24; j++) begin
            for (int i = 0; i < NREQ; i++) opnd[i] = W'($urandom);
            drive_ops();
            bus.req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            job($urandom_range(0, TIMEOUT + 4), W'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
